// File: rtl/x_feed_ctrl.sv
// x_feed_ctrl: loads an activation tile into skewed X shift-register lanes, then shifts the diagonal
// wavefront out to the array; flushes the lane bank after reset.
module x_feed_ctrl #(
  parameter int LANES = 8,
  parameter int DEPTH = 32,
  parameter int DW = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [5:0]               K,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [DW-1:0]            IN_DATA,
  output logic [LANES-1:0]         XR_EN,
  output logic                     XR_WRITE,
  output logic [$clog2(DEPTH)-1:0] XR_IDX,
  output logic [DW-1:0]            XR_DIN,
  output logic                     SHIFT_VALID,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERR
);
  localparam int IW = $clog2(DEPTH);
  localparam int IW1 = IW + 1;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [1:0] {FLUSH, IDLE, LOAD, DRAIN} state_t;
  state_t state, state_n;
  logic [6:0] cnt, cnt_n, d, d_n;
  logic [5:0] kr, kr_n, k, k_n;
  logic [LW-1:0] l, l_n;
  logic [IW:0] idx_w;
  logic beat, wrap, last, ok;
  logic [LANES-1:0] en_n;
  logic wr_n, sv_n, done_n, err_n;
  logic [IW-1:0] idx_n;
  logic [DW-1:0] din_n;
  assign beat = state == LOAD && IN_VALID && IN_READY;
  assign wrap = k == kr - 6'd1;
  assign last = wrap && l == LW'(LANES - 1);
  assign ok = K != 6'd0 && 32'(K) <= 32'(DEPTH - LANES + 1);
  assign idx_w = IW1'(k) + IW1'(l);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 7'd1;
    d_n = d;
    kr_n = kr;
    k_n = k;
    l_n = l;
    en_n = '0;
    wr_n = 1'b0;
    idx_n = '0;
    din_n = '0;
    sv_n = 1'b0;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      FLUSH: begin
        state_n = cnt == 7'(DEPTH) ? IDLE : FLUSH;
        en_n = cnt == 7'(DEPTH) ? '0 : '1;
      end
      IDLE: begin
        cnt_n = '0;
        state_n = START && ok ? LOAD : IDLE;
        kr_n = START && ok ? K : kr;
        k_n = '0;
        l_n = '0;
        err_n = START && !ok;
      end
      LOAD: begin
        cnt_n = '0;
        en_n = beat ? LANES'(1) << l : '0;
        wr_n = beat;
        idx_n = beat ? idx_w[IW-1:0] : '0;
        din_n = beat ? IN_DATA : '0;
        k_n = beat ? (wrap ? 6'd0 : k + 6'd1) : k;
        l_n = beat && wrap ? l + LW'(1) : l;
        state_n = beat && last ? DRAIN : LOAD;
        d_n = 7'(kr) + 7'(LANES - 1);
      end
      default: begin
        // cnt 0 is the last write strobe, 1..d the shift strobes, d+1 the DONE cycle
        en_n = cnt < d ? '1 : '0;
        sv_n = cnt != 7'd0 && cnt <= d;
        done_n = cnt == d;
        state_n = cnt == d + 7'd1 ? IDLE : DRAIN;
      end
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= FLUSH;
      cnt <= '0;
      d <= '0;
      kr <= '0;
      k <= '0;
      l <= '0;
      XR_EN <= '0;
      XR_WRITE <= 1'b0;
      XR_IDX <= '0;
      XR_DIN <= '0;
      IN_READY <= 1'b0;
      SHIFT_VALID <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      ERR <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      d <= d_n;
      kr <= kr_n;
      k <= k_n;
      l <= l_n;
      XR_EN <= en_n;
      XR_WRITE <= wr_n;
      XR_IDX <= idx_n;
      XR_DIN <= din_n;
      IN_READY <= state_n == LOAD;
      SHIFT_VALID <= sv_n;
      BUSY <= state_n != IDLE;
      DONE <= done_n;
      ERR <= err_n;
    end
  end
endmodule

// File: tb/tb_x_feed_ctrl.sv
// tb_x_feed_ctrl: random jobs checked against a lane-bank model and the tile's expected wavefront.
module tb_x_feed_ctrl;
  localparam int LANES = 4;
  localparam int DEPTH = 32;
  localparam int DW = 16;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic START = 1'b0;
  logic [5:0] K = '0;
  logic IN_VALID = 1'b0;
  logic [DW-1:0] IN_DATA = '0;
  logic IN_READY, XR_WRITE, SHIFT_VALID, BUSY, DONE, ERR;
  logic [LANES-1:0] XR_EN;
  logic [4:0] XR_IDX;
  logic [DW-1:0] XR_DIN;
  int checks = 0, errors = 0, cyc = 0;
  logic [DW-1:0] bank [LANES][DEPTH];
  logic [DW-1:0] dq [LANES];
  logic [DW-1:0] got [LANES][$];
  logic [47:0] wlog [$];
  int shifts = 0, sv_cnt = 0, done_cnt = 0, done_cyc = 0, first_shift = 0;
  logic done_busy = 1'b0;

  x_feed_ctrl #(.LANES(LANES), .DEPTH(DEPTH), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .K(K), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .XR_EN(XR_EN), .XR_WRITE(XR_WRITE), .XR_IDX(XR_IDX), .XR_DIN(XR_DIN),
    .SHIFT_VALID(SHIFT_VALID), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, g, e);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({XR_EN, XR_WRITE, XR_IDX, XR_DIN, IN_READY, SHIFT_VALID, BUSY, DONE, ERR});
  endfunction

  function automatic logic [63:0] bank_or();
    logic [DW-1:0] acc = '0;
    for (int l = 0; l < LANES; l++)
      for (int j = 0; j < DEPTH; j++) acc |= bank[l][j];
    return 64'(acc);
  endfunction

  // one cycle: sample at the falling edge and apply the strobes to the lane-bank model
  task automatic step();
    @(negedge CLK);
    cyc++;
    if (SHIFT_VALID) begin
      for (int l = 0; l < LANES; l++) got[l].push_back(dq[l]);
      sv_cnt++;
    end
    if (XR_WRITE && XR_EN != '0) begin
      for (int l = 0; l < LANES; l++) if (XR_EN[l]) bank[l][XR_IDX] = XR_DIN;
      wlog.push_back({16'(cyc), 8'(XR_EN), 8'(XR_IDX), XR_DIN});
    end else if (!XR_WRITE && XR_EN == '1) begin
      for (int l = 0; l < LANES; l++) begin
        dq[l] = bank[l][0];
        for (int j = 0; j < DEPTH - 1; j++) bank[l][j] = bank[l][j+1];
        bank[l][DEPTH-1] = '0;
      end
      if (shifts == 0) first_shift = cyc;
      shifts++;
    end
    if (DONE) begin
      done_cnt++;
      done_cyc = cyc;
      done_busy = BUSY;
    end
  endtask

  task automatic clr();
    wlog.delete();
    for (int l = 0; l < LANES; l++) got[l].delete();
    shifts = 0;
    sv_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic flush_check();
    int n = 0;
    clr();
    step();
    while (n < DEPTH + 8 && XR_EN == '1 && !XR_WRITE && BUSY) begin
      n++;
      step();
    end
    chk("flush_len", 64'(n), 64'(DEPTH));
    chk("idle_after_flush", outs(), 64'd0);
    chk("bank_clean", bank_or(), 64'd0);
  endtask

  task automatic bad_k(input int kk);
    START = 1'b1;
    K = 6'(kk);
    step();
    START = 1'b0;
    chk($sformatf("err_pulse_k%0d", kk), 64'({ERR, IN_READY, BUSY}), 64'b100);
    step();
    chk($sformatf("err_once_k%0d", kk), 64'({ERR, IN_READY, BUSY}), 64'd0);
  endtask

  // mode 0: IN_VALID held, 1: toggling, 2: random; hold keeps START high throughout
  task automatic run_job(input int kk, input int mode, input bit hold, input bit seqd);
    logic [DW-1:0] dat [$];
    int acc [$];
    int n = 0, t = 0, s, fr, d = kk + LANES - 1, idx;
    logic [DW-1:0] e;
    clr();
    START = 1'b1;
    K = 6'(kk);
    s = cyc;
    step();
    if (!hold) START = 1'b0;
    fr = cyc;
    chk("ready_after_start", 64'({IN_READY, BUSY}), 64'b11);
    while (n < LANES * kk && cyc - s < 1500) begin
      IN_VALID = mode == 0 ? 1'b1 : mode == 1 ? ((cyc - fr) % 2 == 0) : 1'($urandom_range(0, 1));
      IN_DATA = seqd ? DW'(n + 1) : DW'($urandom);
      if (hold) K = 6'($urandom);
      if (IN_VALID && IN_READY) begin
        dat.push_back(IN_DATA);
        acc.push_back(cyc);
        n++;
      end
      step();
    end
    IN_VALID = 1'b0;
    chk("beats", 64'(n), 64'(LANES * kk));
    t = acc.size() > 0 ? acc[$] : cyc;
    while (done_cnt == 0 && cyc - t < 200) step();
    chk("done_seen", 64'(done_cnt), 64'd1);
    chk("done_cyc", 64'(done_cyc), 64'(t + 2 + d));
    chk("done_busy", 64'(done_busy), 64'd1);
    chk("first_shift", 64'(first_shift), 64'(t + 2));
    chk("shift_count", 64'(shifts), 64'(d));
    chk("shift_valid_count", 64'(sv_cnt), 64'(d));
    if (mode == 0) chk("job_len", 64'(done_cyc - fr + 1), 64'(LANES * kk + d + 2));
    chk("write_count", 64'(wlog.size()), 64'(LANES * kk));
    for (int i = 0; i < wlog.size() && i < dat.size(); i++)
      chk($sformatf("write_%0d", i), 64'(wlog[i]),
          64'({16'(acc[i] + 1), 8'(1 << (i / kk)), 8'(i % kk + i / kk), dat[i]}));
    for (int l = 0; l < LANES; l++) begin
      chk($sformatf("dout_len_l%0d", l), 64'(got[l].size()), 64'(d));
      for (int j = 0; j < got[l].size() && j < d; j++) begin
        idx = l * kk + j - l;
        e = (j >= l && j - l < kk && idx < dat.size()) ? dat[idx] : '0;
        chk($sformatf("dout_l%0d_%0d", l, j), 64'(got[l][j]), 64'(e));
      end
    end
    step();
    chk("idle_after_done", outs(), 64'd0);
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("bank_clean_after_job", bank_or(), 64'd0);
  endtask

  task automatic abort_job();
    int n = 0, b = 0;
    clr();
    START = 1'b1;
    K = 6'd3;
    step();
    START = 1'b0;
    while (n < 5 && b < 100) begin
      IN_VALID = 1'b1;
      IN_DATA = DW'($urandom) | DW'(1);
      if (IN_READY) n++;
      b++;
      step();
    end
    IN_VALID = 1'b0;
    chk("abort_beats", 64'(n), 64'd5);
    RST = 1'b1;
    #1;
    chk("abort_outs", outs(), 64'd0);
    step();
    step();
    RST = 1'b0;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    flush_check();
  endtask

  initial begin
    for (int l = 0; l < LANES; l++) begin
      dq[l] = '0;
      for (int j = 0; j < DEPTH; j++) bank[l][j] = DW'($urandom) | DW'(1);
    end
    repeat (3) @(negedge CLK);
    chk("reset_outs", outs(), 64'd0);
    RST = 1'b0;
    flush_check();
    run_job(3, 0, 1'b0, 1'b1);
    bad_k(0);
    bad_k(30);
    bad_k(63);
    run_job(2, 1, 1'b0, 1'b1);
    run_job(29, 0, 1'b0, 1'b0);
    run_job(1, 2, 1'b0, 1'b0);
    abort_job();
    run_job(1, 0, 1'b0, 1'b0);
    run_job(4, 2, 1'b1, 1'b0);
    run_job(2, 0, 1'b0, 1'b0);
    repeat (6) run_job(int'($urandom_range(1, 29)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
